// File: rtl/sram_mem_stage.sv
// Memory-stage word access over a 16-bit async SRAM as two halfword phases (2*WAIT_CYCLES+2 cycles, ready low while busy).
// Optional SRAM_ALIGN_CHECK_EN: misaligned requests skip the SRAM, complete in one cycle and set sticky align_err.
module sram_mem_stage #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               align_err
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               wr_q;
  logic [SRAM_AW-2:0] w_q;
  logic [31:0]        data_q;
  logic               req;
  logic               misalign;
  logic               cnt_last;
  logic [31:0]        off;
  logic               unused_bits;

  assign req         = MEM_R_EN | MEM_W_EN;
  assign off         = address - BASE_ADDR;
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_ALIGN_CHECK_EN
  assign misalign = |address[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = misalign ? DONE : LO;
      LO:      if (cnt_last) state_d = HI;
      HI:      if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      w_q       <= '0;
      data_q    <= '0;
      read_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q   <= MEM_W_EN;
            // halfword address is 2*w, so only the low SRAM_AW-1 bits of w survive
            w_q    <= off[SRAM_AW:2];
            data_q <= write_data;
            cnt_q  <= '0;
            if (misalign && !MEM_W_EN) read_data <= '0;
          end
        end
        LO, HI: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (!wr_q) begin
              if (state_q == LO) read_data[15:0]  <= sram_dq_in;
              else               read_data[31:16] <= sram_dq_in;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              align_err <= 1'b0;
    else if (state_q == IDLE && req && misalign) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif

  // SRAM pins come only from registered state and latched fields
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    case (state_q)
      LO: begin
        sram_addr   = {w_q, 1'b0};
        sram_dq_out = data_q[15:0];
        sram_we_n   = ~wr_q;
        sram_dq_oe  = wr_q;
      end
      HI: begin
        sram_addr   = {w_q, 1'b1};
        sram_dq_out = data_q[31:16];
        sram_we_n   = ~wr_q;
        sram_dq_oe  = wr_q;
      end
      default: ;
    endcase
  end

  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule

// File: doc/sram_mem_stage.md
# sram_mem_stage

Memory-stage data-memory controller for the ARM pipeline. Consumes the execute stage's memory request (address = ALU result, store data = Rm value, read/write enables) and performs a 32-bit word access on an external 16-bit asynchronous SRAM as two halfword transfers. It holds `ready` low for the duration of the access so the hazard/freeze logic can stall the pipeline.

## Interface
Parameters:
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM halfword 0.
- `WAIT_CYCLES`, 2: clock cycles each halfword phase is held; must be ≥1.
- `SRAM_AW`, 18: SRAM halfword address width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `MEM_R_EN`  in  1  load request; held by the pipeline until `ready`.
- `MEM_W_EN`  in  1  store request; held by the pipeline until `ready`.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  load result; valid in the cycle `ready`=1 that ends a load.
- `ready`  out  1  high when no access is pending or in progress; low while busy.
- `sram_addr`  out  SRAM_AW  halfword address.
- `sram_dq_out`  out  16  write data to the SRAM.
- `sram_dq_in`  in  16  read data from the SRAM.
- `sram_dq_oe`  out  1  data-bus output enable; high only during write phases.
- `sram_we_n`  out  1  active-low write strobe.
- `align_err`  out  1  sticky misalignment flag. Exists only with `SRAM_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If `MEM_W_EN` or `MEM_R_EN` is high, latch `address`, `write_data` and op, clear the phase counter, and go to LO.
  - `MEM_W_EN` has priority when both are high (the access is a write).
- Word index: `w = (address - BASE_ADDR) >> 2`, modulo 2^32. Halfword address: `2*w`, truncated to SRAM_AW bits (wraps silently). `address[1:0]` is ignored unless the macro is enabled.
- LO:
  - Drives `sram_addr` = 2w and `sram_dq_out` = data[15:0].
  - On a write, `sram_we_n`=0 and `sram_dq_oe`=1.
  - Counter runs 0..WAIT_CYCLES-1. On the last cycle, a read captures `sram_dq_in` into `read_data[15:0]`; then go to HI.
- HI: same as LO with `sram_addr` = 2w+1 and bits [31:16].
- DONE: `ready`=1 for exactly one cycle, then go to IDLE. A request still high in the following IDLE cycle is a new access (back-to-back).
- `ready` = (state==IDLE and no request) or state==DONE. It is combinational from the registered state and the enables.
- `sram_we_n`, `sram_dq_oe`, `sram_addr` and `sram_dq_out` derive only from registered state and latched fields, never directly from the pipeline inputs.
- Outside LO/HI: `sram_we_n`=1 and `sram_dq_oe`=0.
- `read_data` holds its value until the next load overwrites it; stores do not change it.

## Timing
- Request first seen in IDLE at cycle 0:
  - LO covers cycles 1..W; HI covers cycles W+1..2W; DONE is cycle 2W+1 (W = WAIT_CYCLES).
  - `ready` is low in cycles 0..2W. With the default W=2, `ready` goes high at cycle 5, giving a 6-cycle access.
- With no request, `ready`=1 continuously and the stage adds zero stall.
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_we_n` 1, `sram_dq_oe` 0, `align_err` 0, `ready` follows the request inputs.
- Reset mid-access: the access aborts immediately (asynchronously), `sram_we_n` returns to 1, and the partially captured `read_data` is cleared.

## Configuration
- `SRAM_ALIGN_CHECK_EN` defined:
  - A request with `address[1:0]`≠0 goes IDLE→DONE directly, with no SRAM cycles and no write strobe.
  - `read_data` becomes 0 for a read.
  - `align_err` is set and stays set until reset.
  - `ready` goes high at cycle 1.
- `SRAM_ALIGN_CHECK_EN` undefined: low address bits are ignored; `align_err` is constant 0.

## Test plan
- Write 0xDEADBEEF at 1024 (W=2) -> SRAM halfword 0 = 0xBEEF and halfword 1 = 0xDEAD; `sram_we_n` low for 4 cycles; `ready` low cycles 0–4, high cycle 5.
- Read 1024 after the write above -> `read_data` = 0xDEADBEEF in the `ready` cycle (cycle 5); `sram_dq_oe` stays 0 throughout.
- Write 0x12345678 at 1028, then immediately read 1028 with both enables held across DONE -> second access starts the cycle after DONE, ends at cycle 11 with 0x12345678; halfwords 2 and 3 are 0x5678 and 0x1234.
- Both enables high at 1032 with data 0xA5A5A5A5 -> treated as a write; `read_data` is unchanged.
- Deassert `rst_n` during HI of a write -> `sram_we_n`=1 and state IDLE with no clock edge; `read_data`=0; next access completes normally.
- With `SRAM_ALIGN_CHECK_EN`, read at 1026 -> no SRAM strobe, `ready`=1 at cycle 1, `read_data`=0, `align_err`=1 and sticky; without the macro, same request reads halfwords 0/1.
